mod_exp: RTL
============

Name: mod_exp

Overview:
- Sequential modular exponentiator: result = base^exp mod modulus.
- Right-to-left square-and-multiply built on a bit-serial interleaved modular multiplier.
- Consumes the private/public exponents produced by the key-setup gcd/inverse block; this is the encrypt/decrypt engine of the RSA datapath.
- Default build has data-dependent latency, which is the timing-leak target; an optional build makes latency constant.

Parameters:
- W, 16, operand width in bits for base, exp, modulus and result.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- base  in  W  base operand; must be < modulus
- exp  in  W  exponent
- modulus  in  W  modulus n
- result  out  W  base^exp mod n; valid from the finish pulse until the next accepted start
- busy  out  1  high from the cycle after start is accepted until finish
- finish  out  1  one-cycle completion pulse
- err  out  1  high with finish when operands are illegal; held until the next accepted start

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; result=0, busy=0, finish=0, err=0; all internal registers cleared. Reset mid-operation aborts immediately, with no finish.
- IDLE: on posedge with start=1, latch base, exp and modulus; call this edge E0. Operand changes after E0 are ignored. start while busy is ignored.
- Illegal operands: modulus==0 or base>=modulus.
  - At E0+1: finish=1, err=1, result=0, busy stays 0; return to IDLE.
- Legal operands: at E0+1 go to MUL or SQR for bit i=0. Registers: R=1 mod n (R=0 when n==1), B=base, E=exp.
- Per exponent bit i = 0..W-1, LSB first:
  - MUL phase (only if E[i]=1): R = R*B mod n, exactly W cycles.
  - SQR phase (always): B = B*B mod n, exactly W cycles.
- Modular multiply X*Y mod n: interleaved, scanning X MSB-first, one bit per cycle.
  - Each cycle: P = 2P, subtract n if P>=n; then if the X bit is set, P = P+Y, subtract n if P>=n.
  - Intermediates are W+1 bits wide, so one conditional subtraction per step suffices because operands are < n.
- After the SQR phase of bit W-1: DONE for one cycle.
  - finish=1, busy=0, result=R, err=0; then IDLE.
- Latency: finish is high after edge E0 + W*(W + popcount(exp)) + 1, where popcount is the number of 1 bits in exp.
- Special cases:
  - exp==0 gives result = 1 mod n.
  - n==1 gives result 0 with full latency and err=0.
- busy=1 over exactly the MUL/SQR cycles.
- A start coincident with the finish cycle is ignored; the next start is accepted one cycle later, in IDLE.

Optional Feature:
- Macro: MOD_EXP_CONST_TIME_EN.
- Defined:
  - The MUL phase runs for every bit.
  - When E[i]=0, its product is written to a dummy register and R is unchanged.
  - Latency is always W*2W + 1, which is 513 for W=16.
  - The result is identical to the default build.
- Undefined: data-dependent latency as specified above.

Test Plan:
1. base=4, exp=13, modulus=497, start pulse -> finish after E0+305 (16*19+1), result=445, err=0; busy high for 304 cycles. Const-time build: E0+513, same result.
2. base=7, exp=560, modulus=561 -> result=1, finish after E0+305. Then base=3, exp=0, modulus=7 -> result=1, finish after E0+257.
3. base=10, modulus=7 (any exp), then modulus=0 -> each gives finish and err=1 at E0+1, result=0, busy never asserted.
4. base=0, exp=5, modulus=1 -> result=0, err=0, finish after E0+289.
5. Start base=4, exp=13, modulus=497; assert rst_n=0 at E0+100 for 2 cycles -> all outputs 0 immediately, no finish. Restart with the same operands -> result=445 after a full 305 cycles.
6. start re-pulsed at E0+50 with different operands -> ignored; the original result 445 is returned at E0+305.

Source files
------------

// File: rtl/mod_exp.sv
// Sequential modular exponentiator (right-to-left square-and-multiply over a
// bit-serial interleaved modular multiplier). Define MOD_EXP_CONST_TIME_EN for constant latency.
module mod_exp #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exp,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         finish,
    output logic         err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_SQR  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  e_q, e_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q, err_d;
`ifdef MOD_EXP_CONST_TIME_EN
    logic [W-1:0]  dummy_q, dummy_d;
`endif

    logic [W-1:0]  x_op;
    logic [CW-1:0] x_idx;
    logic          x_bit;
    logic [W:0]    n_ext;
    logic [W:0]    p_dbl;
    logic [W:0]    p_red1;
    logic [W:0]    p_add;
    logic [W:0]    p_red2;
    logic [W-1:0]  prod;
    logic          mul_last;
    logic [CW-1:0] bit_next;
    logic          first_mul;
    logic          next_mul;

    // One interleaved step: P = 2P mod n, then P = P + Y mod n when the X bit is set.
    // Y is always B (R*B or B*B), so only the scanned operand changes with the phase.
    always_comb begin
        x_op     = (state_q == S_SQR) ? b_q : r_q;
        x_idx    = CW'(W - 1) - cnt_q;
        x_bit    = x_op[x_idx];
        n_ext    = {1'b0, n_q};
        p_dbl    = {p_q, 1'b0};
        p_red1   = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
        p_add    = p_red1 + {1'b0, b_q};
        p_red2   = x_bit ? ((p_add >= n_ext) ? (p_add - n_ext) : p_add) : p_red1;
        prod     = p_red2[W-1:0];
        mul_last = (cnt_q == CW'(W - 1));
        bit_next = bit_q + CW'(1);
`ifdef MOD_EXP_CONST_TIME_EN
        first_mul = 1'b1;
        next_mul  = 1'b1;
`else
        first_mul = e_q[0];
        next_mul  = e_q[bit_next];
`endif
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        b_d      = b_q;
        e_d      = e_q;
        n_d      = n_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef MOD_EXP_CONST_TIME_EN
        dummy_d  = dummy_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d      = base;
                    e_d      = exp;
                    n_d      = modulus;
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if ((n_q == '0) || (b_q >= n_q)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    r_d     = (n_q == W'(1)) ? '0 : W'(1);
                    p_d     = '0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = first_mul ? S_MUL : S_SQR;
                end
            end
            S_MUL: begin
                p_d   = prod;
                cnt_d = cnt_q + CW'(1);
                if (mul_last) begin
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_SQR;
`ifdef MOD_EXP_CONST_TIME_EN
                    if (e_q[bit_q]) begin
                        r_d = prod;
                    end else begin
                        dummy_d = prod;
                    end
`else
                    r_d = prod;
`endif
                end
            end
            S_SQR: begin
                p_d   = prod;
                cnt_d = cnt_q + CW'(1);
                if (mul_last) begin
                    p_d   = '0;
                    cnt_d = '0;
                    b_d   = prod;
                    if (bit_q == CW'(W - 1)) begin
                        result_d = r_q;
                        state_d  = S_DONE;
                    end else begin
                        bit_d   = bit_next;
                        state_d = next_mul ? S_MUL : S_SQR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            b_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef MOD_EXP_CONST_TIME_EN
            dummy_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            b_q      <= b_d;
            e_q      <= e_d;
            n_q      <= n_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef MOD_EXP_CONST_TIME_EN
            dummy_q  <= dummy_d;
`endif
        end
    end

    assign result = result_q;
    assign err    = err_q;
    assign finish = (state_q == S_DONE);
    assign busy   = (state_q == S_MUL) || (state_q == S_SQR);

endmodule
